timer_sched: RTL

Scheduler that shares one countdown timer among `NREQ` requesters. Each requester submits a cycle count through a valid/ready handshake. A round-robin arbiter grants one request at a time and loads the shared counter. When the count expires, a one-cycle `done` pulse returns to the owning requester. The block sits between client FSMs and the single timer resource, so each client does not need its own counter.

---
 rtl/timer_sched_pkg.sv | 12 +
 rtl/timer_sched_rr_arbiter.sv | 33 +++
 rtl/timer_sched.sv | 98 +++++++++
 3 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the timer_sched shared-countdown scheduler.
package timer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// Combinational NREQ-way round-robin arbiter: one-hot grant plus its index,
// searching from ptr upward with wrap. Grants nothing while en is low.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    int j;

    // Walk offsets from farthest to nearest so the requester closest to ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        j     = 0;
        if (en) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                j = (int'(ptr) + k) % NREQ;
                if (req[j]) begin
                    grant    = '0;
                    grant[j] = 1'b1;
                    idx      = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/timer_sched.sv
// One countdown timer shared by NREQ requesters via round-robin grant.
// Optional owner abort is compiled in with TIMER_SCHED_ABORT_EN.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_cycles,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
`ifdef TIMER_SCHED_ABORT_EN
    output logic [$clog2(NREQ)-1:0]  owner,
    input  logic [NREQ-1:0]          abort
`else
    output logic [$clog2(NREQ)-1:0]  owner
`endif
);

    localparam int IW = $clog2(NREQ);

    sched_state_t                   state, state_nx;
    logic [WIDTH-1:0]               counter;
    logic [IW-1:0]                  rr_ptr, gidx;
    logic [NREQ-1:0]                grant;
    logic [NREQ-1:0][WIDTH-1:0]     cyc_arr;
    logic                           accept, expire, abort_hit;

    assign cyc_arr = req_cycles;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (state == IDLE),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign expire    = (counter <= WIDTH'(1));
    assign busy      = (state != IDLE);

`ifdef TIMER_SCHED_ABORT_EN
    assign abort_hit = (state == RUN) && abort[owner];
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN: begin
                if (abort_hit)   state_nx = IDLE;
                else if (expire) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        done = '0;
        if (state == DONE) done[owner] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            owner   <= '0;
            rr_ptr  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // A zero count still gets one RUN cycle.
                        counter <= (cyc_arr[gidx] == '0) ? WIDTH'(1) : cyc_arr[gidx];
                        owner   <= gidx;
                        rr_ptr  <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    end
                end
                RUN: begin
                    if (abort_hit)    counter <= '0;
                    else if (!expire) counter <= counter - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
